// File: rtl/sar_pkg.sv
// Shared types and helpers for the parametrised successive-approximation register.
package sar_pkg;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } sar_state_e;

    // Map a requested conversion length onto 1..width; 0 or oversize means full width.
    function automatic int unsigned clamp_nbits(input int unsigned nbits, input int unsigned width);
        if ((nbits == 32'd0) || (nbits > width)) begin
            return width;
        end else begin
            return nbits;
        end
    endfunction

endpackage

// File: rtl/sar_reg_param.sv
// Successive-approximation register: walks an active-low trial bit MSB first,
// takes one comparator decision per enabled clock, latches the finished code
// with a one-cycle valid strobe and can auto-restart for continuous conversion.
module sar_reg_param
    import sar_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int NB_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             e,
    input  logic             s,
    input  logic             d,
    input  logic [NB_W-1:0]  nbits,
    input  logic             cont,
    output logic [WIDTH-1:0] q,
    output logic             d0,
    output logic             cc_n,
    output logic [WIDTH-1:0] result,
    output logic             valid
);

    sar_state_e       state_q,  state_d;
    logic [NB_W-1:0]  step_q,   step_d;
    logic [NB_W-1:0]  nb_q,     nb_d;
    logic [WIDTH-1:0] trial_q,  trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cc_n_q,   cc_n_d;
    logic             valid_q,  valid_d;
    logic             d0_q,     d0_d;

    logic [NB_W-1:0]  nb_clamped_s;
    logic [WIDTH-1:0] decided_s;
    logic [WIDTH-1:0] advanced_s;
    logic [WIDTH-1:0] keep_mask_s;
    logic             last_s;
    int               trial_pos_s;
    int               drop_bits_s;

    assign nb_clamped_s = NB_W'(clamp_nbits(32'(nbits), 32'(WIDTH)));
    assign trial_pos_s  = WIDTH - 1 - int'(step_q);
    assign drop_bits_s  = WIDTH - int'(nb_q);
    assign last_s       = ((step_q + NB_W'(1)) == nb_q);

    // Code with the current decision folded in, the code advanced to the next
    // trial bit, and the mask that zeroes the LSBs a short conversion never decides.
    always_comb begin
        decided_s   = trial_q;
        advanced_s  = trial_q;
        keep_mask_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (i == trial_pos_s) begin
                decided_s[i]  = d;
                advanced_s[i] = d;
            end else if (i == (trial_pos_s - 1)) begin
                advanced_s[i] = 1'b0;
            end else begin
                advanced_s[i] = trial_q[i];
            end
            if (i >= drop_bits_s) begin
                keep_mask_s[i] = 1'b1;
            end else begin
                keep_mask_s[i] = 1'b0;
            end
        end
    end

    // Next-state logic: a disabled clock holds everything, a low start re-arms
    // from any state, otherwise the sequencer decides, completes or restarts.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        nb_d     = nb_q;
        trial_d  = trial_q;
        result_d = result_q;
        cc_n_d   = cc_n_q;
        valid_d  = valid_q;
        d0_d     = d0_q;
        if (e) begin
            d0_d    = d;
            valid_d = 1'b0;
            if (!s) begin
                state_d = CONV;
                step_d  = {NB_W{1'b0}};
                nb_d    = nb_clamped_s;
                trial_d = {1'b0, {(WIDTH-1){1'b1}}};
                cc_n_d  = 1'b1;
            end else begin
                case (state_q)
                    CONV: begin
                        if (last_s) begin
                            trial_d  = decided_s;
                            result_d = decided_s & keep_mask_s;
                            cc_n_d   = 1'b0;
                            valid_d  = 1'b1;
                            state_d  = DONE;
                        end else begin
                            trial_d = advanced_s;
                            step_d  = step_q + NB_W'(1);
                        end
                    end
                    DONE: begin
                        if (cont) begin
                            // Auto-restart reuses the length latched at the last start.
                            state_d = CONV;
                            step_d  = {NB_W{1'b0}};
                            trial_d = {1'b0, {(WIDTH-1){1'b1}}};
                            cc_n_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    IDLE: begin
                        state_d = IDLE;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous return to the idle code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            step_q   <= {NB_W{1'b0}};
            nb_q     <= NB_W'(WIDTH);
            trial_q  <= {WIDTH{1'b1}};
            result_q <= {WIDTH{1'b0}};
            cc_n_q   <= 1'b0;
            valid_q  <= 1'b0;
            d0_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            nb_q     <= nb_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            cc_n_q   <= cc_n_d;
            valid_q  <= valid_d;
            d0_q     <= d0_d;
        end
    end

    assign q      = trial_q;
    assign d0     = d0_q;
    assign cc_n   = cc_n_q;
    assign result = result_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_sar_reg_param.sv
// Self-checking bench for sar_reg_param (WIDTH = 12): expected results and
// completion cycles are queued when a conversion is started and checked
// when the valid strobe appears.
module tb_sar_reg_param;

    localparam int WIDTH = 12;
    localparam int NB_W  = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst_n;
    logic             e;
    logic             s;
    logic             d;
    logic [NB_W-1:0]  nbits;
    logic             cont;
    logic [WIDTH-1:0] q;
    logic             d0;
    logic             cc_n;
    logic [WIDTH-1:0] result;
    logic             valid;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   cyc;
    logic en_at_edge;

    sar_reg_param #(.WIDTH(WIDTH), .NB_W(NB_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .e      (e),
        .s      (s),
        .d      (d),
        .nbits  (nbits),
        .cont   (cont),
        .q      (q),
        .d0     (d0),
        .cc_n   (cc_n),
        .result (result),
        .valid  (valid)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n decisions; mode 0 alternates 1,0,... starting at index k0, 1 = all ones, 2 = all zeros.
    task automatic decide(input int n, input int mode, input int k0);
        for (int k = k0; k < k0 + n; k++) begin
            if (mode == 0) d = (k % 2 == 0);
            else if (mode == 1) d = 1'b1;
            else d = 1'b0;
            tick();
        end
    endtask

    // Scoreboard: count edges and compare each valid pulse against the queue.
    always @(posedge clk) begin
        cyc = cyc + 1;
        en_at_edge = e;
        #1;
        if (en_at_edge && valid && rst_n) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(valid), 32'd0);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("result", 32'(result), 32'(x.res));
                chk("latency", 32'(cyc), 32'(x.cyc));
            end
        end
    end

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b0; e = 1'b1; s = 1'b1; d = 1'b0; nbits = NB_W'(12); cont = 1'b0;
        #23;
        chk("rst_q", 32'(q), 32'hFFF);
        chk("rst_d0", 32'(d0), 32'd0);
        chk("rst_cc_n", 32'(cc_n), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_hold_q", 32'(q), 32'hFFF);

        // 1: full 12-bit conversion, alternating decisions.
        nbits = NB_W'(12); s = 1'b0;
        exp_q.push_back('{12'hAAA, cyc + 13});
        tick();
        chk("t1_arm_q", 32'(q), 32'h7FF);
        chk("t1_arm_cc_n", 32'(cc_n), 32'd1);
        s = 1'b1;
        decide(1, 0, 0);
        chk("t1_q_step1", 32'(q), 32'hBFF);
        chk("t1_d0", 32'(d0), 32'd1);
        decide(11, 0, 1);
        chk("t1_cc_n", 32'(cc_n), 32'd0);
        chk("t1_valid", 32'(valid), 32'd1);
        chk("t1_q", 32'(q), 32'hAAA);
        tick();
        chk("t1_valid_1cyc", 32'(valid), 32'd0);
        chk("t1_hold_cc_n", 32'(cc_n), 32'd0);

        // 2: short 8-bit conversion, all ones.
        nbits = NB_W'(8); s = 1'b0;
        exp_q.push_back('{12'hFF0, cyc + 9});
        tick();
        s = 1'b1;
        decide(7, 1, 0);
        chk("t2_cc_n_busy", 32'(cc_n), 32'd1);
        decide(1, 1, 7);
        chk("t2_cc_n", 32'(cc_n), 32'd0);
        chk("t2_q_lsbs", 32'(q[3:0]), 32'hF);
        tick();

        // 3: continuous mode, 4-bit, all zeros: three back-to-back results.
        nbits = NB_W'(4); cont = 1'b1; s = 1'b0;
        exp_q.push_back('{12'h000, cyc + 5});
        exp_q.push_back('{12'h000, cyc + 10});
        exp_q.push_back('{12'h000, cyc + 15});
        tick();
        s = 1'b1;
        decide(4, 2, 0);
        chk("t3_q_done", 32'(q), 32'h0FF);
        decide(1, 2, 0);
        chk("t3_rearm_q", 32'(q), 32'h7FF);
        decide(5, 2, 0);
        chk("t3_rearm2_q", 32'(q), 32'h7FF);
        decide(4, 2, 0);
        cont = 1'b0;
        tick();
        tick();
        chk("t3_stop_cc_n", 32'(cc_n), 32'd0);

        // 4: clock enable low for 3 cycles mid-conversion.
        nbits = NB_W'(12); s = 1'b0;
        exp_q.push_back('{12'hAAA, cyc + 16});
        tick();
        s = 1'b1;
        decide(5, 0, 0);
        chk("t4_q_before", 32'(q), 32'hABF);
        e = 1'b0; d = 1'b0;
        tick(); tick(); tick();
        chk("t4_q_frozen", 32'(q), 32'hABF);
        chk("t4_d0_frozen", 32'(d0), 32'd1);
        chk("t4_cc_n_frozen", 32'(cc_n), 32'd1);
        e = 1'b1;
        decide(7, 0, 5);
        chk("t4_cc_n", 32'(cc_n), 32'd0);
        tick();

        // 5: start pulsed low at step 5 aborts and restarts.
        s = 1'b0;
        tick();
        s = 1'b1;
        decide(5, 1, 0);
        s = 1'b0;
        exp_q.push_back('{12'hAAA, cyc + 13});
        tick();
        chk("t5_restart_q", 32'(q), 32'h7FF);
        chk("t5_no_valid", 32'(valid), 32'd0);
        s = 1'b1;
        decide(12, 0, 0);
        tick();

        // nbits = 0 means full width.
        nbits = NB_W'(0); s = 1'b0;
        exp_q.push_back('{12'hFFF, cyc + 13});
        tick();
        s = 1'b1;
        decide(12, 1, 0);
        tick();

        // 6: asynchronous reset at step 7.
        nbits = NB_W'(12); s = 1'b0;
        tick();
        s = 1'b1;
        decide(7, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_q", 32'(q), 32'hFFF);
        chk("t6_cc_n", 32'(cc_n), 32'd0);
        chk("t6_result", 32'(result), 32'd0);
        chk("t6_valid", 32'(valid), 32'd0);
        #10 rst_n = 1'b1;
        tick();
        tick();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
